sync_fifo_flags: RTL and testbench

//  Single-clock FIFO, parametrised width/depth; successor of the basic sync FIFO.

---
 rtl/sync_fifo_pkg.sv | 20 ++
 rtl/sync_fifo_ptr.sv | 45 ++++
 rtl/sync_fifo_flags.sv | 131 +++++++++++++
 tb/tb_sync_fifo_flags.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and defaults for the flagged single-clock FIFO.
// The SYNC_FIFO_FWFT_EN read mode is selected inside sync_fifo_flags, not here.
package sync_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

    // Occupancy needs one more bit than the address so that DEPTH itself fits.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Wrapping FIFO pointer with a lap toggle, which flips each time the pointer wraps.
// The toggle lets equal pointers be read as either full or empty.
module sync_fifo_ptr #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  inc_i,
    output logic [ADDR_WIDTH-1:0] ptr_o,
    output logic                  tgl_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  tgl_q, tgl_d;

    always_comb begin
        ptr_d = ptr_q;
        tgl_d = tgl_q;
        if (inc_i) begin
            if (ptr_q == LAST) begin
                ptr_d = '0;
                tgl_d = ~tgl_q;
            end else begin
                ptr_d = ptr_q + ADDR_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            tgl_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            tgl_q <= tgl_d;
        end
    end

    assign ptr_o = ptr_q;
    assign tgl_o = tgl_q;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost flags and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; the default is a registered read.
module sync_fifo_flags
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  rd_en_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  rvalid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] AF_CNT = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT = CW'(AE_LEVEL);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("sync_fifo_flags: DEPTH must be a power of 2 and at least 2");
    end
    if (!((AE_LEVEL < AF_LEVEL) && (AF_LEVEL <= DEPTH))) begin : g_bad_levels
        $error("sync_fifo_flags: need AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic                  wr_tgl, rd_tgl;
    logic                  wr_acc, rd_acc;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, underflow_q;
    fifo_status_t          status;

    assign status.empty        = (wr_ptr == rd_ptr) && (wr_tgl == rd_tgl);
    assign status.full         = (wr_ptr == rd_ptr) && (wr_tgl != rd_tgl);
    assign status.almost_full  = (count_q >= AF_CNT);
    assign status.almost_empty = (count_q <= AE_CNT);

    assign wr_acc = wr_en_i && !status.full;
    assign rd_acc = rd_en_i && !status.empty;

    sync_fifo_ptr #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (wr_acc),
        .ptr_o  (wr_ptr),
        .tgl_o  (wr_tgl)
    );

    sync_fifo_ptr #(.DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (rd_acc),
        .ptr_o  (rd_ptr),
        .tgl_o  (rd_tgl)
    );

    // Storage is deliberately left out of reset; the pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            overflow_q  <= wr_en_i && status.full;
            underflow_q <= rd_en_i && status.empty;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is shown directly; forced to zero while empty so it never exposes stale storage.
    assign rdata_o  = status.empty ? '0 : mem[rd_ptr];
    assign rvalid_o = !status.empty;
`else
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc) begin
                rdata_q <= mem[rd_ptr];
            end
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
`endif

    assign full_o         = status.full;
    assign empty_o        = status.empty;
    assign almost_full_o  = status.almost_full;
    assign almost_empty_o = status.almost_empty;
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags (WIDTH=8, DEPTH=16): a vector table plus hand sequences.
// Build with SYNC_FIFO_FWFT_EN defined to exercise the first-word-fall-through read path.
module tb_sync_fifo_flags;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             wr_en_i = 1'b0;
    logic [WIDTH-1:0] wdata_i = '0;
    logic             rd_en_i = 1'b0;
    logic [WIDTH-1:0] rdata_o;
    logic             rvalid_o, full_o, empty_o, almost_full_o, almost_empty_o;
    logic [4:0]       count_o;
    logic             overflow_o, underflow_o;

    int errors = 0;
    int checks = 0;
    logic [WIDTH-1:0] q[$];

    sync_fifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .wr_en_i        (wr_en_i),
        .wdata_i        (wdata_i),
        .rd_en_i        (rd_en_i),
        .rdata_o        (rdata_o),
        .rvalid_o       (rvalid_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o),
        .underflow_o    (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic             wr;
        logic [WIDTH-1:0] wd;
        logic             rd;
        int               cnt;
        logic             emp;
        logic             ful;
        logic             af;
        logic             ae;
        logic             ovf;
        logic             udf;
    } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    // One clock of stimulus checked against a queue reference model of the FIFO.
    task automatic do_op(input logic wr, input logic [WIDTH-1:0] wd, input logic rd);
        bit               wacc, racc, eovf, eudf;
        int               n;
        logic [WIDTH-1:0] exp_rd;
        n      = q.size();
        wacc   = wr && (n < DEPTH);
        racc   = rd && (n != 0);
        eovf   = wr && (n == DEPTH);
        eudf   = rd && (n == 0);
        exp_rd = racc ? q[0] : '0;
        wr_en_i = wr;
        wdata_i = wd;
        rd_en_i = rd;
`ifdef SYNC_FIFO_FWFT_EN
        if (racc) check("fwft_head_rdata", int'(rdata_o), int'(exp_rd));
`endif
        cyc();
        if (racc) void'(q.pop_front());
        if (wacc) q.push_back(wd);
        n = q.size();
        check("count", int'(count_o), n);
        check("empty", int'(empty_o), int'(n == 0));
        check("full", int'(full_o), int'(n == DEPTH));
        check("almost_full", int'(almost_full_o), int'(n >= DEPTH - 2));
        check("almost_empty", int'(almost_empty_o), int'(n <= 2));
        check("overflow", int'(overflow_o), int'(eovf));
        check("underflow", int'(underflow_o), int'(eudf));
`ifdef SYNC_FIFO_FWFT_EN
        check("fwft_rvalid", int'(rvalid_o), int'(n != 0));
        if (n != 0) check("fwft_rdata_next", int'(rdata_o), int'(q[0]));
`else
        check("rvalid", int'(rvalid_o), int'(racc));
        if (racc) check("rdata", int'(rdata_o), int'(exp_rd));
`endif
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
    endtask

    vec_t vecs[11];

    initial begin
        // Hand-computed walk through the almost-empty region and empty-side corners.
        vecs[0]  = '{1'b1, 8'hA1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'hA2, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'hA3, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'hA4, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 8'hB5, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        rst_ni = 1'b0;
        cyc();
        cyc();
        check("reset_count", int'(count_o), 0);
        check("reset_empty", int'(empty_o), 1);
        check("reset_full", int'(full_o), 0);
        check("reset_ae", int'(almost_empty_o), 1);
        check("reset_af", int'(almost_full_o), 0);
        check("reset_rvalid", int'(rvalid_o), 0);
        check("reset_rdata", int'(rdata_o), 0);
        check("reset_ovf", int'(overflow_o), 0);
        check("reset_udf", int'(underflow_o), 0);
        rst_ni = 1'b1;
        cyc();

        // Table vectors
        q.delete();
        foreach (vecs[i]) begin
            do_op(vecs[i].wr, vecs[i].wd, vecs[i].rd);
            check($sformatf("vec%0d_count", i), int'(count_o), vecs[i].cnt);
            check($sformatf("vec%0d_empty", i), int'(empty_o), int'(vecs[i].emp));
            check($sformatf("vec%0d_full", i), int'(full_o), int'(vecs[i].ful));
            check($sformatf("vec%0d_af", i), int'(almost_full_o), int'(vecs[i].af));
            check($sformatf("vec%0d_ae", i), int'(almost_empty_o), int'(vecs[i].ae));
            check($sformatf("vec%0d_ovf", i), int'(overflow_o), int'(vecs[i].ovf));
            check($sformatf("vec%0d_udf", i), int'(underflow_o), int'(vecs[i].udf));
        end

        // Reset mid-stream with 5 entries
        for (int i = 0; i < 5; i++) do_op(1'b1, 8'h50 + 8'(i), 1'b0);
        #2 rst_ni = 1'b0;
        #1;
        check("midrst_empty", int'(empty_o), 1);
        check("midrst_count", int'(count_o), 0);
        check("midrst_rvalid", int'(rvalid_o), 0);
        #2 rst_ni = 1'b1;
        q.delete();
        cyc();
        check("postrst_empty", int'(empty_o), 1);
        do_op(1'b0, 8'h00, 1'b1);
        check("postrst_underflow", int'(underflow_o), 1);
        check("postrst_count", int'(count_o), 0);
        do_op(1'b0, 8'h00, 1'b0);
        check("underflow_one_cycle", int'(underflow_o), 0);

        // Fill 0x00..0x0F, first-write visibility, then drain in order
        do_op(1'b1, 8'h00, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
        check("fwft_first_rvalid", int'(rvalid_o), 1);
        check("fwft_first_rdata", int'(rdata_o), 0);
`else
        check("std_no_read_rvalid", int'(rvalid_o), 0);
`endif
        for (int i = 1; i < 16; i++) begin
            do_op(1'b1, 8'(i), 1'b0);
            if (i == 12) check("af_below_14", int'(almost_full_o), 0);
            if (i == 13) check("af_at_14", int'(almost_full_o), 1);
        end
        check("fill_full", int'(full_o), 1);
        check("fill_count", int'(count_o), 16);
        for (int i = 0; i < 16; i++) do_op(1'b0, 8'h00, 1'b1);
        check("drain_empty", int'(empty_o), 1);

        // 20 consecutive writes: 17..20 overflow, then readback 0..15
        for (int i = 0; i < 20; i++) begin
            do_op(1'b1, 8'(i), 1'b0);
            if (i >= 16) check("ovf_write", int'(overflow_o), 1);
        end
        check("ovf_count", int'(count_o), 16);
        for (int i = 0; i < 16; i++) do_op(1'b0, 8'h00, 1'b1);
        check("ovf_drain_empty", int'(empty_o), 1);

        // Full then wr+rd, then steady state at 8 with pointer wrap
        for (int i = 0; i < 16; i++) do_op(1'b1, 8'(i), 1'b0);
        do_op(1'b1, 8'hEE, 1'b1);
        check("full_wrrd_ovf", int'(overflow_o), 1);
        check("full_wrrd_count", int'(count_o), 15);
`ifndef SYNC_FIFO_FWFT_EN
        check("full_wrrd_rdata", int'(rdata_o), 0);
`endif
        for (int i = 0; i < 7; i++) do_op(1'b0, 8'h00, 1'b1);
        check("steady_start_count", int'(count_o), 8);
        for (int k = 0; k < 40; k++) do_op(1'b1, 8'h40 + 8'(k), 1'b1);
        check("steady_end_count", int'(count_o), 8);
        for (int i = 0; i < 8; i++) do_op(1'b0, 8'h00, 1'b1);
        check("steady_drain_empty", int'(empty_o), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
